input_conditioner: RTL
======================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the key stable-time in clocks (20 ms at 50 MHz).
REQ-002 The module SHALL have parameter SW_STABLE_CYCLES, default 500000, giving the switch stable-time in clocks.
REQ-003 The module SHALL have parameter REPEAT_DELAY, default 25000000, giving the clocks from debounced press to the first repeat pulse.
REQ-004 The module SHALL have parameter REPEAT_PERIOD, default 10000000, giving the clocks between subsequent repeat pulses.
REQ-005 The module SHALL have port CLOCK_50, input, 1 bit: system clock.
REQ-006 The module SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The module SHALL have port key_in, input, 2 bits: raw push-buttons, active-low, asynchronous; bit0 is Confirm, bit1 is Back.
REQ-008 The module SHALL have port sw_in, input, 10 bits: raw slide switches, asynchronous.
REQ-009 The module SHALL have port key_pulse, output, 2 bits: one-cycle press strobe per key.
REQ-010 The module SHALL have port key_held, output, 2 bits: debounced level per key, 1 while pressed.
REQ-011 The module SHALL have port sw_out, output, 10 bits: synchronized and filtered switch value.
REQ-012 The module SHALL have port sw_change, output, 1 bit: one-cycle strobe on the cycle sw_out updates.

Function
REQ-013 Each key_in bit SHALL pass through a 2-flop synchronizer with reset value 1 before any other use.
REQ-014 Each key SHALL have an independent FSM with states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-015 Each key FSM SHALL have one counter of width $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1).
REQ-016 In RELEASED, a synchronized low SHALL move the FSM to PRESS_WAIT with the counter cleared to 0.
REQ-017 In PRESS_WAIT, a synchronized high SHALL return the FSM to RELEASED with no pulse.
REQ-018 In PRESS_WAIT with the input still low, the counter SHALL increment each clock; when it equals DEBOUNCE_CYCLES-1, the FSM SHALL enter PRESSED, key_pulse SHALL be 1 for exactly one cycle, and the counter SHALL clear.
REQ-019 A clean press SHALL give key_pulse high for the cycle following the (DEBOUNCE_CYCLES+3)th rising edge after key_in falls.
REQ-020 In PRESSED, a synchronized high SHALL move the FSM to RELEASE_WAIT with the counter cleared.
REQ-021 In RELEASE_WAIT, a synchronized low SHALL return the FSM to PRESSED with no pulse.
REQ-022 In RELEASE_WAIT, after DEBOUNCE_CYCLES consecutive high samples the FSM SHALL enter RELEASED.
REQ-023 key_held SHALL be 1 in PRESSED and RELEASE_WAIT and 0 otherwise; release SHALL never pulse.
REQ-024 The two keys SHALL be independent; both key_pulse bits MAY be 1 in the same cycle.
REQ-025 sw_in SHALL pass through a 2-flop synchronizer with reset value 0.
REQ-026 A stability counter SHALL clear whenever the synchronized switch value differs from its value in the previous clock.
REQ-027 When the synchronized value has held for SW_STABLE_CYCLES clocks and differs from sw_out, sw_out SHALL load that value and sw_change SHALL be 1 for one cycle.
REQ-028 The switch stability counter SHALL saturate at SW_STABLE_CYCLES and SHALL NOT wrap.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 On reset_n low, all key FSMs SHALL go to RELEASED and all counters SHALL clear, immediately and regardless of current state.
REQ-031 Reset SHALL force key_pulse=0, key_held=0, sw_out=0 and sw_change=0.
REQ-032 Reset SHALL set the key synchronizers to 1 and the switch synchronizers to 0.
REQ-033 After reset_n releases, a key already held low SHALL produce one key_pulse after the normal debounce time.

Configuration
REQ-034 With AUTO_REPEAT_EN defined, a key that stays in PRESSED SHALL pulse REPEAT_DELAY clocks after its press pulse, then every REPEAT_PERIOD clocks until the FSM leaves PRESSED.
REQ-035 With AUTO_REPEAT_EN defined, entering RELEASE_WAIT SHALL cancel repeat timing, and a return to PRESSED SHALL restart REPEAT_DELAY.
REQ-036 Without AUTO_REPEAT_EN, the module SHALL give exactly one pulse per debounced press, and REPEAT_DELAY and REPEAT_PERIOD SHALL have no effect.

Verification (bench parameters DEBOUNCE_CYCLES=4, SW_STABLE_CYCLES=3, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-037 Clean press: key_in[0] falls at edge 0 and holds -> key_pulse[0] is high only after edge 7 and key_held[0] rises with it.
REQ-038 Bounce: key_in[1] toggles low/high every 2 clocks for 20 clocks, then stays low -> no pulse during bouncing, and exactly one pulse DEBOUNCE_CYCLES+3 edges after the final fall.
REQ-039 Release glitch: while pressed, key_in[0] goes high for 2 clocks -> no new pulse and key_held stays 1.
REQ-040 Switch settle: sw_in goes 0x000->0x005, glitches to 0x007 for 1 clock, then returns to 0x005 -> sw_out=0x005 with one sw_change pulse, and 0x007 never appears.
REQ-041 Reset mid-press: reset_n pulses low while in PRESS_WAIT with the key held -> outputs are 0 at once, then one pulse 7 edges after reset_n releases.
REQ-042 AUTO_REPEAT_EN: key held 30 clocks after its press pulse -> repeat pulses at +10, +15, +20, +25 and +30.

Source files
------------

// File: rtl/input_conditioner.sv
// Push-button debouncer with press strobes and slide-switch synchronizer/filter.
// Define AUTO_REPEAT_EN to make held keys emit repeat pulses.
module input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES  = 1000000,
   parameter int unsigned SW_STABLE_CYCLES = 500000,
   parameter int unsigned REPEAT_DELAY     = 25000000,
   parameter int unsigned REPEAT_PERIOD    = 10000000
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic [1:0] key_in,
   input  logic [9:0] sw_in,
   output logic [1:0] key_pulse,
   output logic [1:0] key_held,
   output logic [9:0] sw_out,
   output logic       sw_change
);

   localparam int unsigned MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int unsigned MAX_CNT = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
   localparam int unsigned SW_W    = $clog2(SW_STABLE_CYCLES + 1);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [SW_W-1:0]  SW_LAST = SW_W'(SW_STABLE_CYCLES);
`ifdef AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } key_state_t;

   logic [1:0] key_meta;
   logic [1:0] key_sync;

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         key_meta <= '1;
         key_sync <= '1;
      end else begin
         key_meta <= key_in;
         key_sync <= key_meta;
      end
   end

   for (genvar k = 0; k < 2; k++) begin : g_key
      key_state_t       state;
      logic [CNT_W-1:0] cnt;
      logic             pulse_r;
      logic             held_r;

      assign key_pulse[k] = pulse_r;
      assign key_held[k]  = held_r;

`ifdef AUTO_REPEAT_EN
      // rep_phase selects the period after the first repeat; anything but a low sample in PRESSED restarts the delay
      logic rep_phase;
      logic rep_hit;

      assign rep_hit = !key_sync[k] && (cnt == (rep_phase ? RP_LAST : RD_LAST));

      always_ff @(posedge CLOCK_50 or negedge reset_n) begin
         if (!reset_n)
            rep_phase <= 1'b0;
         else if (state == PRESSED && !key_sync[k])
            rep_phase <= rep_phase | rep_hit;
         else
            rep_phase <= 1'b0;
      end
`endif

      always_ff @(posedge CLOCK_50 or negedge reset_n) begin
         if (!reset_n) begin
            state   <= RELEASED;
            cnt     <= '0;
            pulse_r <= 1'b0;
            held_r  <= 1'b0;
         end else begin
            pulse_r <= 1'b0;
            case (state)
               RELEASED: begin
                  held_r <= 1'b0;
                  if (!key_sync[k]) begin
                     state <= PRESS_WAIT;
                     cnt   <= '0;
                  end
               end
               PRESS_WAIT: begin
                  if (key_sync[k]) begin
                     state <= RELEASED;
                  end else if (cnt == DB_LAST) begin
                     state   <= PRESSED;
                     cnt     <= '0;
                     pulse_r <= 1'b1;
                     held_r  <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               PRESSED: begin
                  if (key_sync[k]) begin
                     state <= RELEASE_WAIT;
                     cnt   <= '0;
                  end else begin
`ifdef AUTO_REPEAT_EN
                     if (rep_hit) begin
                        cnt     <= '0;
                        pulse_r <= 1'b1;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
`endif
                  end
               end
               RELEASE_WAIT: begin
                  if (!key_sync[k]) begin
                     state <= PRESSED;
                     cnt   <= '0;
                  end else if (cnt == DB_LAST) begin
                     state  <= RELEASED;
                     cnt    <= '0;
                     held_r <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: begin
                  state <= RELEASED;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

   logic [9:0]      sw_meta;
   logic [9:0]      sw_sync;
   logic [9:0]      sw_prev;
   logic [SW_W-1:0] sw_cnt;

   // Load only on an unchanged sample so a saturated counter cannot pass a fresh edge straight through
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         sw_meta   <= '0;
         sw_sync   <= '0;
         sw_prev   <= '0;
         sw_cnt    <= '0;
         sw_out    <= '0;
         sw_change <= 1'b0;
      end else begin
         sw_meta   <= sw_in;
         sw_sync   <= sw_meta;
         sw_prev   <= sw_sync;
         sw_change <= 1'b0;
         if (sw_sync != sw_prev)
            sw_cnt <= '0;
         else if (sw_cnt != SW_LAST)
            sw_cnt <= sw_cnt + 1'b1;
         if (sw_sync == sw_prev && sw_cnt == SW_LAST && sw_sync != sw_out) begin
            sw_out    <= sw_sync;
            sw_change <= 1'b1;
         end
      end
   end

endmodule
